hs32_alu_arb: RTL and testbench
===============================

Name: hs32_alu_arb

Overview:
- Shares the single HS32 ALU between two requesters: port 0 is the execute stage and port 1 is the address-generation/auxiliary unit.
- Owns the architectural NZCV flags register. It feeds the current flags to the ALU and commits the ALU flag outputs on request.
- Allows one operation in flight. The registered result is held on a response port under a valid/ready handshake.
- Sits between the decode/execute control and the combinational ALU.

Parameters:
- FL_RESET, 4'b0000, reset value of the NZCV flags register (bit3=N, bit2=Z, bit1=C, bit0=V).
- PRIO_FIXED, 0, grant policy: 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- r0_valid_i  in  1  port 0 request valid.
- r0_ready_o  out  1  port 0 request accepted this cycle.
- r0_a_i  in  32  port 0 operand A.
- r0_b_i  in  32  port 0 operand B.
- r0_op_i  in  4  port 0 ALU opcode (HS32A_* encoding).
- r0_setfl_i  in  1  port 0: commit ALU flags on accept.
- r1_valid_i, r1_ready_o, r1_a_i, r1_b_i, r1_op_i, r1_setfl_i  same as port 0, for port 1.
- alu_a_o  out  32  to ALU operand A.
- alu_b_o  out  32  to ALU operand B.
- alu_op_o  out  4  to ALU opcode.
- alu_fl_o  out  4  to ALU flags in; always equals flags_o.
- alu_r_i  in  32  from ALU result.
- alu_fl_i  in  4  from ALU flags out.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_id_o  out  1  port that issued the response.
- rsp_r_o  out  32  registered result.
- rsp_fl_o  out  4  registered ALU flag outputs of that operation, whether or not they were committed.
- fl_we_i  in  1  direct flags write (interrupt restore / flags move).
- fl_d_i  in  4  direct flags write data.
- flags_o  out  4  current flags register.

Behaviour:
- States: IDLE (rsp_valid_o=0) and HOLD (rsp_valid_o=1).
- can_accept = (state==IDLE) || rsp_ready_i.
- Grant is combinational and decided only from the valids:
  - Only one port valid: that port is granted.
  - Both valid, PRIO_FIXED=1: port 0 is granted.
  - Both valid, PRIO_FIXED=0: the port not recorded in last_q is granted.
- rN_ready_o = can_accept && granted==N. At most one ready is high per cycle.
- ALU drive: alu_a/b/op_o come from the granted port. With no valid, they are driven to 0.
- Accept (valid && ready), registered at the next edge:
  - rsp_r_o <= alu_r_i; rsp_fl_o <= alu_fl_i; rsp_id_o <= port.
  - rsp_valid_o <= 1; last_q <= port.
  - If setfl, flags_q <= alu_fl_i.
  - Latency is 1 cycle from accept to rsp_valid_o.
- HOLD with rsp_ready_i=1 and no accept: rsp_valid_o <= 0, go to IDLE.
- HOLD with rsp_ready_i=1 and an accept: stay in HOLD and load the new response. This gives back-to-back throughput of 1 op/cycle.
- HOLD with rsp_ready_i=0: all rsp_* outputs are held stable and both readies are low.
- Flag forwarding: an op accepted the cycle after a setfl accept sees the updated flags on alu_fl_o. No bubble is needed.
- fl_we_i: flags_q <= fl_d_i at the edge.
  - If it coincides with a setfl accept, fl_we_i wins.
  - rsp_fl_o still captures alu_fl_i.
- Requesters must hold valid and payload until ready. The block does not check this.
- last_q updates only on accept. Requesters being idle does not change fairness.
- Reset (asynchronous, any state, including mid-HOLD):
  - rsp_valid_o=0, rsp_r_o=0, rsp_fl_o=0, rsp_id_o=0.
  - flags_q=FL_RESET; last_q=1, so port 0 wins the first tie; state=IDLE.
  - A response pending at reset is dropped.
- No internal arithmetic. All results come from the ALU unmodified, at 32 bits.

Test Plan:
- Single op: reset, r0 ADD a=5 b=7 setfl=1, rsp_ready_i=1. Required: r0_ready_o=1 in the same cycle; next cycle rsp_valid_o=1, rsp_id_o=0, rsp_r_o=12, flags_o=4'b0000.
- Round-robin: PRIO_FIXED=0, both ports valid for 4 cycles, rsp_ready_i=1. Required: grants 0,1,0,1; rsp_id_o sequence 0,1,0,1 one cycle later. With PRIO_FIXED=1, all grants go to port 0.
- Backpressure: rsp_ready_i=0 after the first accept. Required: rsp_r_o held and both readies 0 for 5 cycles. On rsp_ready_i=1, the queued r1 request is accepted in that same cycle.
- Flag forwarding: r0 SUB 3-3 setfl=1, next cycle r1 op with setfl=0. Required: alu_fl_o=4'b0100 (Z set) during the second op; flags_o is unchanged by the second op.
- Flags write conflict: fl_we_i=1, fl_d_i=4'b1111 in the same cycle as a setfl SUB 1-2 accept. Required: flags_o=4'b1111; rsp_fl_o=ALU output; rsp_r_o=32'hFFFFFFFF.
- Async reset mid-HOLD: assert reset between clock edges while rsp_valid_o=1. Required: rsp_valid_o drops immediately; flags_o=FL_RESET; the next tie is granted to port 0.

Source files
------------

// File: rtl/hs32_alu_arb.sv
// hs32_alu_arb: two-port arbiter for the shared HS32 ALU with NZCV flags register and registered response.
module hs32_alu_arb #(
  parameter logic [3:0] FL_RESET   = 4'b0000,
  parameter bit         PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid_i,
  output logic        r0_ready_o,
  input  logic [31:0] r0_a_i,
  input  logic [31:0] r0_b_i,
  input  logic [3:0]  r0_op_i,
  input  logic        r0_setfl_i,
  input  logic        r1_valid_i,
  output logic        r1_ready_o,
  input  logic [31:0] r1_a_i,
  input  logic [31:0] r1_b_i,
  input  logic [3:0]  r1_op_i,
  input  logic        r1_setfl_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_op_o,
  output logic [3:0]  alu_fl_o,
  input  logic [31:0] alu_r_i,
  input  logic [3:0]  alu_fl_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_r_o,
  output logic [3:0]  rsp_fl_o,
  input  logic        fl_we_i,
  input  logic [3:0]  fl_d_i,
  output logic [3:0]  flags_o
);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  flags_q, flags_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_r_q, rsp_r_d;
  logic [3:0]  rsp_fl_q, rsp_fl_d;
  logic        any_v, gnt, can_accept, accept, setfl;
  always_comb begin
    any_v      = r0_valid_i || r1_valid_i;
    // on a tie the port that did not win the last accept goes first
    gnt        = (r0_valid_i && r1_valid_i) ? (PRIO_FIXED ? 1'b0 : !last_q) : r1_valid_i;
    can_accept = (state_q == IDLE) || rsp_ready_i;
    accept     = can_accept && any_v;
    setfl      = gnt ? r1_setfl_i : r0_setfl_i;
    state_d    = accept ? HOLD : (rsp_ready_i ? IDLE : state_q);
    last_d     = accept ? gnt : last_q;
    rsp_id_d   = accept ? gnt : rsp_id_q;
    rsp_r_d    = accept ? alu_r_i : rsp_r_q;
    rsp_fl_d   = accept ? alu_fl_i : rsp_fl_q;
    flags_d    = fl_we_i ? fl_d_i : ((accept && setfl) ? alu_fl_i : flags_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      flags_q  <= FL_RESET;
      rsp_id_q <= 1'b0;
      rsp_r_q  <= '0;
      rsp_fl_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      flags_q  <= flags_d;
      rsp_id_q <= rsp_id_d;
      rsp_r_q  <= rsp_r_d;
      rsp_fl_q <= rsp_fl_d;
    end
  end
  assign r0_ready_o  = can_accept && r0_valid_i && !gnt;
  assign r1_ready_o  = can_accept && r1_valid_i && gnt;
  assign alu_a_o     = any_v ? (gnt ? r1_a_i : r0_a_i) : '0;
  assign alu_b_o     = any_v ? (gnt ? r1_b_i : r0_b_i) : '0;
  assign alu_op_o    = any_v ? (gnt ? r1_op_i : r0_op_i) : '0;
  assign alu_fl_o    = flags_q;
  assign flags_o     = flags_q;
  assign rsp_valid_o = (state_q == HOLD);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_r_o     = rsp_r_q;
  assign rsp_fl_o    = rsp_fl_q;
endmodule

// File: tb/tb_hs32_alu_arb.sv
// tb_hs32_alu_arb: round-robin and fixed-priority instances against a transaction-level reference model.
module tb_hs32_alu_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        r0v[2], r1v[2], r0s[2], r1s[2], r0r[2], r1r[2];
  logic [31:0] r0a[2], r0b[2], r1a[2], r1b[2];
  logic [3:0]  r0op[2], r1op[2];
  logic [31:0] alua[2], alub[2], alur[2];
  logic [3:0]  aluop[2], alufl_o[2], alufl_i[2];
  logic        rspv[2], rsprdy[2], rspid[2], flwe[2];
  logic [31:0] rsp_r[2];
  logic [3:0]  rsp_fl[2], fld[2], flags[2];
  int n_tests = 0;
  int n_fail = 0;
  bit          m_hv[2], m_id[2], m_last[2], acc0[2], acc1[2];
  logic [31:0] m_r[2];
  logic [3:0]  m_fl[2], m_flags[2];
  always #5 clk = ~clk;
  // ALU environment: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADC, others pass B; returns {N,Z,C,V,result}
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] fl);
    logic [32:0] s;
    logic c, v;
    s = {1'b0, b};
    c = fl[1];
    v = fl[0];
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[32]; v = (a[31] == b[31]) && (s[31] != a[31]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; c = s[32]; v = (a[31] != b[31]) && (s[31] != a[31]); end
      4'd2: s = {1'b0, a & b};
      4'd3: s = {1'b0, a | b};
      4'd4: s = {1'b0, a ^ b};
      4'd5: begin s = {1'b0, a} + {1'b0, b} + {32'd0, fl[1]}; c = s[32]; v = (a[31] == b[31]) && (s[31] != a[31]); end
      default: ;
    endcase
    return {s[31], s[31:0] == 32'd0, c, v, s[31:0]};
  endfunction
  function automatic logic [3:0] fl_rst(input int k);
    return (k == 1) ? 4'b1010 : 4'b0000;
  endfunction
  for (genvar k = 0; k < 2; k++) begin : g_dut
    hs32_alu_arb #(.FL_RESET((k == 1) ? 4'b1010 : 4'b0000), .PRIO_FIXED(k == 1)) dut (
      .clk(clk), .reset(reset),
      .r0_valid_i(r0v[k]), .r0_ready_o(r0r[k]), .r0_a_i(r0a[k]), .r0_b_i(r0b[k]), .r0_op_i(r0op[k]), .r0_setfl_i(r0s[k]),
      .r1_valid_i(r1v[k]), .r1_ready_o(r1r[k]), .r1_a_i(r1a[k]), .r1_b_i(r1b[k]), .r1_op_i(r1op[k]), .r1_setfl_i(r1s[k]),
      .alu_a_o(alua[k]), .alu_b_o(alub[k]), .alu_op_o(aluop[k]), .alu_fl_o(alufl_o[k]),
      .alu_r_i(alur[k]), .alu_fl_i(alufl_i[k]),
      .rsp_valid_o(rspv[k]), .rsp_ready_i(rsprdy[k]), .rsp_id_o(rspid[k]), .rsp_r_o(rsp_r[k]), .rsp_fl_o(rsp_fl[k]),
      .fl_we_i(flwe[k]), .fl_d_i(fld[k]), .flags_o(flags[k])
    );
    always_comb {alufl_i[k], alur[k]} = alu_f(aluop[k], alua[k], alub[k], alufl_o[k]);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      m_hv[k] = 0; m_id[k] = 0; m_last[k] = 1; m_r[k] = '0; m_fl[k] = '0; m_flags[k] = fl_rst(k);
      acc0[k] = 0; acc1[k] = 0;
    end
  endtask
  // called at a negedge: checks outputs against the model, advances the model, moves to the next negedge
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit can, g, any, e0, e1;
      logic [35:0] res;
      can = !m_hv[k] || rsprdy[k];
      any = r0v[k] || r1v[k];
      g = (r0v[k] && r1v[k]) ? ((k == 1) ? 1'b0 : !m_last[k]) : r1v[k];
      e0 = can && r0v[k] && !g;
      e1 = can && r1v[k] && g;
      chk($sformatf("r0_ready[%0d]", k), 32'(r0r[k]), 32'(e0));
      chk($sformatf("r1_ready[%0d]", k), 32'(r1r[k]), 32'(e1));
      chk($sformatf("alu_a[%0d]", k), alua[k], any ? (g ? r1a[k] : r0a[k]) : 32'd0);
      chk($sformatf("alu_b[%0d]", k), alub[k], any ? (g ? r1b[k] : r0b[k]) : 32'd0);
      chk($sformatf("alu_op[%0d]", k), 32'(aluop[k]), any ? 32'(g ? r1op[k] : r0op[k]) : 32'd0);
      chk($sformatf("alu_fl[%0d]", k), 32'(alufl_o[k]), 32'(m_flags[k]));
      chk($sformatf("flags[%0d]", k), 32'(flags[k]), 32'(m_flags[k]));
      chk($sformatf("rsp_valid[%0d]", k), 32'(rspv[k]), 32'(m_hv[k]));
      if (m_hv[k]) begin
        chk($sformatf("rsp_id[%0d]", k), 32'(rspid[k]), 32'(m_id[k]));
        chk($sformatf("rsp_r[%0d]", k), rsp_r[k], m_r[k]);
        chk($sformatf("rsp_fl[%0d]", k), 32'(rsp_fl[k]), 32'(m_fl[k]));
      end
      acc0[k] = e0;
      acc1[k] = e1;
      if (e0 || e1) begin
        res = g ? alu_f(r1op[k], r1a[k], r1b[k], m_flags[k]) : alu_f(r0op[k], r0a[k], r0b[k], m_flags[k]);
        m_hv[k] = 1; m_id[k] = g; m_last[k] = g; m_r[k] = res[31:0]; m_fl[k] = res[35:32];
        if (g ? r1s[k] : r0s[k]) m_flags[k] = res[35:32];
      end else if (rsprdy[k]) m_hv[k] = 0;
      if (flwe[k]) m_flags[k] = fld[k];
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 32'(rspv[k]), 32'd0);
      chk($sformatf("rst_r[%0d]", k), rsp_r[k], 32'd0);
      chk($sformatf("rst_id[%0d]", k), 32'(rspid[k]), 32'd0);
      chk($sformatf("rst_fl[%0d]", k), 32'(rsp_fl[k]), 32'd0);
      chk($sformatf("rst_flags[%0d]", k), 32'(flags[k]), 32'(fl_rst(k)));
    end
    reset_model();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic set_req(input int p, input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit s);
    for (int k = 0; k < 2; k++) begin
      if (p == 0) begin r0v[k] = v; r0op[k] = op; r0a[k] = a; r0b[k] = b; r0s[k] = s; end
      else begin r1v[k] = v; r1op[k] = op; r1a[k] = a; r1b[k] = b; r1s[k] = s; end
    end
  endtask
  task automatic set_ctl(input bit rdy, input bit we, input logic [3:0] d);
    for (int k = 0; k < 2; k++) begin rsprdy[k] = rdy; flwe[k] = we; fld[k] = d; end
  endtask
  task automatic rand_drive();
    for (int k = 0; k < 2; k++) begin
      if (!r0v[k] || acc0[k]) begin
        r0v[k] = $urandom_range(0, 2) != 0; r0op[k] = 4'($urandom_range(0, 7));
        r0a[k] = $urandom; r0b[k] = ($urandom_range(0, 3) == 0) ? r0a[k] : $urandom; r0s[k] = 1'($urandom_range(0, 1));
      end
      if (!r1v[k] || acc1[k]) begin
        r1v[k] = $urandom_range(0, 2) != 0; r1op[k] = 4'($urandom_range(0, 7));
        r1a[k] = $urandom; r1b[k] = ($urandom_range(0, 3) == 0) ? r1a[k] : $urandom; r1s[k] = 1'($urandom_range(0, 1));
      end
      rsprdy[k] = $urandom_range(0, 3) != 0;
      flwe[k] = $urandom_range(0, 9) == 0;
      fld[k] = 4'($urandom);
    end
  endtask
  initial begin
    logic [31:0] held;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    set_ctl(1, 0, 0);
    @(negedge clk);
    do_reset();
    // round robin vs fixed priority from a fresh reset
    set_req(0, 1, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    set_req(1, 1, 4'd3, 32'h0000_00A5, 32'h5A00_0000, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", 32'(r1r[0]), 32'(i % 2));
      chk("fixed_grant", 32'(r0r[1]), 32'd1);
      step();
      chk("rr_rsp_id", 32'(rspid[0]), 32'(i % 2));
    end
    // single op with setfl
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 4'd0, 32'd5, 32'd7, 1);
    step();
    chk("single_r", rsp_r[0], 32'd12);
    chk("single_id", 32'(rspid[0]), 32'd0);
    chk("single_flags", 32'(flags[0]), 32'd0);
    // backpressure with a queued r1 request
    set_req(0, 1, 4'd4, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    step();
    held = rsp_r[0];
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    set_ctl(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_held", rsp_r[0], held);
    end
    set_ctl(1, 0, 0);
    #1;
    chk("bp_release", 32'(r1r[0]), 32'd1);
    step();
    // flag forwarding
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 4'd1, 32'd3, 32'd3, 1);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 4'd5, 32'd1, 32'd1, 0);
    #1;
    chk("fwd_alu_fl", 32'(alufl_o[0]), 32'h4);
    step();
    chk("fwd_flags", 32'(flags[0]), 32'h4);
    chk("fwd_r", rsp_r[0], 32'd2);
    // direct flags write colliding with a setfl accept
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 4'd1, 32'd1, 32'd2, 1);
    set_ctl(1, 1, 4'hF);
    step();
    chk("we_flags", 32'(flags[0]), 32'hF);
    chk("we_rsp_fl", 32'(rsp_fl[0]), 32'hA);
    chk("we_rsp_r", rsp_r[0], 32'hFFFF_FFFF);
    // asynchronous reset while a response is held
    set_req(0, 0, 0, 0, 0, 0);
    set_ctl(0, 0, 0);
    chk("pre_rst_valid", 32'(rspv[0]), 32'd1);
    do_reset();
    set_req(0, 1, 4'd0, 32'd10, 32'd20, 0);
    set_req(1, 1, 4'd0, 32'd30, 32'd40, 0);
    set_ctl(1, 0, 0);
    #1;
    chk("post_rst_tie", 32'(r0r[0]), 32'd1);
    step();
    for (int i = 0; i < 600; i++) begin
      rand_drive();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
